// File: rtl/fpu_altinp_arb_if.sv
// fpu_altinp_arb_if: producer pushes, lane hold/flush and ALTDATA outputs of the alt-input arbiter
interface fpu_altinp_arb_if #(parameter int WIDTH = 68);
  logic src0_valid, src1_valid, src2_valid;
  logic [WIDTH-1:0] src0_data, src1_data, src2_data;
  logic src0_ready, src1_ready, src2_ready;
  logic hold, flush;
  logic [1:0] ALT_INP;
  logic [WIDTH-1:0] ALTDATA0, ALTDATA1;
  logic ovf;
  modport master (
    output src0_valid, src1_valid, src2_valid, src0_data, src1_data, src2_data, hold, flush,
    input src0_ready, src1_ready, src2_ready, ALT_INP, ALTDATA0, ALTDATA1, ovf
  );
  modport slave (
    input src0_valid, src1_valid, src2_valid, src0_data, src1_data, src2_data, hold, flush,
    output src0_ready, src1_ready, src2_ready, ALT_INP, ALTDATA0, ALTDATA1, ovf
  );
endinterface

// File: rtl/fpu_altinp_arb.sv
// fpu_altinp_arb: three source FIFOs drained round-robin, up to two per cycle, onto ALTDATA0/1
module fpu_altinp_arb #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  fpu_altinp_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [2:0] valid, ready, elig, push, pop;
  logic [WIDTH-1:0] din [3];
  logic [WIDTH-1:0] head [3];
  logic [1:0] rr, p1, p2, g0, g1, last;
  logic g0v, g1v, act;
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  assign valid = {bus.src2_valid, bus.src1_valid, bus.src0_valid};
  assign din[0] = bus.src0_data;
  assign din[1] = bus.src1_data;
  assign din[2] = bus.src2_data;
  assign {bus.src2_ready, bus.src1_ready, bus.src0_ready} = ready;
  assign act = ~bus.hold & ~bus.flush;
  // priority order is rr, rr+1, rr+2; channel 1 takes the next eligible source after channel 0
  assign p1 = inc3(rr);
  assign p2 = inc3(p1);
  assign g0v = elig[rr] | elig[p1] | elig[p2];
  assign g0 = elig[rr] ? rr : elig[p1] ? p1 : p2;
  assign g1v = elig[rr] ? (elig[p1] | elig[p2]) : (elig[p1] & elig[p2]);
  assign g1 = elig[rr] & elig[p1] ? p1 : p2;
  assign last = g1v ? g1 : g0;
  for (genvar i = 0; i < 3; i++) begin : g_src
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] wp, rp;
    assign ready[i] = cnt != CW'(DEPTH);
    assign elig[i] = cnt != '0;
    assign push[i] = valid[i] & ready[i] & ~bus.flush;
    assign pop[i] = act & ((g0v & (g0 == 2'(i))) | (g1v & (g1 == 2'(i))));
    assign head[i] = mem[rp];
    always_ff @(posedge clk)
      if (push[i]) mem[wp] <= din[i];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt <= '0;
        wp <= '0;
        rp <= '0;
      end else if (bus.flush) begin
        cnt <= '0;
        wp <= '0;
        rp <= '0;
      end else begin
        cnt <= cnt + CW'(push[i]) - CW'(pop[i]);
        wp <= wp + AW'(push[i]);
        rp <= rp + AW'(pop[i]);
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.ALT_INP <= 2'b00;
      bus.ALTDATA0 <= '0;
      bus.ALTDATA1 <= '0;
      bus.ovf <= 1'b0;
      rr <= 2'd0;
    end else begin
      bus.ALT_INP <= {act & g1v, act & g0v};
      bus.ALTDATA0 <= act & g0v ? head[g0] : '0;
      bus.ALTDATA1 <= act & g1v ? head[g1] : '0;
      if (act & g0v) rr <= inc3(last);
      if (|(valid & ~ready)) bus.ovf <= 1'b1;
    end
endmodule

// File: tb/tb_fpu_altinp_arb.sv
// tb_fpu_altinp_arb: directed vectors with a cycle-stamped scoreboard checked by a separate monitor
module tb_fpu_altinp_arb;
  logic clk = 0;
  logic rst = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int b;
  typedef struct {
    logic [1:0] v;
    logic [67:0] d0, d1;
    int c;
  } exp_t;
  exp_t q[$];
  fpu_altinp_arb_if #(.WIDTH(68)) bus();
  fpu_altinp_arb #(.WIDTH(68), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus.ALT_INP != 2'b00 || (q.size() > 0 && q[0].c <= cyc))) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got alt=%b d0=%h d1=%h at cyc %0d, want no output", bus.ALT_INP, bus.ALTDATA0, bus.ALTDATA1, cyc);
      end else begin
        e = q.pop_front();
        if (bus.ALT_INP !== e.v || bus.ALTDATA0 !== e.d0 || bus.ALTDATA1 !== e.d1 || cyc != e.c) begin
          errors++;
          $display("FAIL out: got alt=%b d0=%h d1=%h cyc=%0d, want alt=%b d0=%h d1=%h cyc=%0d", bus.ALT_INP, bus.ALTDATA0, bus.ALTDATA1, cyc, e.v, e.d0, e.d1, e.c);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [67:0] a, input logic [67:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic expect_out(input logic [1:0] v, input logic [67:0] d0, input logic [67:0] d1, input int c);
    q.push_back('{v, d0, d1, c});
  endtask
  task automatic step(input logic [2:0] v, input logic [67:0] a, input logic [67:0] bb, input logic [67:0] c, input logic h = 1'b0, input logic f = 1'b0);
    bus.src0_valid = v[0];
    bus.src1_valid = v[1];
    bus.src2_valid = v[2];
    bus.src0_data = a;
    bus.src1_data = bb;
    bus.src2_data = c;
    bus.hold = h;
    bus.flush = f;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 68'h0, 68'h0, 68'h0);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step(3'b000, 68'h0, 68'h0, 68'h0);
    chk("drain", 68'(q.size()), 68'h0);
  endtask
  task automatic do_reset();
    rst = 0;
    bus.src0_valid = 0; bus.src1_valid = 0; bus.src2_valid = 0;
    bus.src0_data = '0; bus.src1_data = '0; bus.src2_data = '0;
    bus.hold = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask
  function automatic logic [67:0] rdy();
    return 68'({bus.src2_ready, bus.src1_ready, bus.src0_ready});
  endfunction
  initial begin
    do_reset();
    chk("rst_alt", 68'(bus.ALT_INP), 68'h0);
    chk("rst_d0", bus.ALTDATA0, 68'h0);
    chk("rst_d1", bus.ALTDATA1, 68'h0);
    chk("rst_ovf", 68'(bus.ovf), 68'h0);
    chk("rst_ready", rdy(), 68'h7);
    // single push from src1; rr moves to 2, so a later burst starts at src2
    b = cyc;
    expect_out(2'b01, 68'h1, 68'h0, b + 2);
    step(3'b010, 68'h0, 68'h1, 68'h0);
    idle(3);
    b = cyc;
    expect_out(2'b11, 68'h12, 68'h10, b + 2);
    expect_out(2'b01, 68'h11, 68'h0, b + 3);
    step(3'b111, 68'h10, 68'h11, 68'h12);
    idle(3);
    drain();
    // two entries per source, drained round-robin
    do_reset();
    b = cyc;
    expect_out(2'b11, 68'h0A, 68'h1A, b + 3);
    expect_out(2'b11, 68'h2A, 68'h0B, b + 4);
    expect_out(2'b11, 68'h1B, 68'h2B, b + 5);
    step(3'b111, 68'h0A, 68'h1A, 68'h2A, 1'b1);
    step(3'b111, 68'h0B, 68'h1B, 68'h2B, 1'b1);
    chk("full_ready", rdy(), 68'h0);
    idle(5);
    drain();
    // overflow on src0 under hold
    do_reset();
    b = cyc;
    expect_out(2'b01, 68'hA0, 68'h0, b + 4);
    expect_out(2'b01, 68'hA1, 68'h0, b + 5);
    chk("ovf_ready0", rdy(), 68'h7);
    step(3'b001, 68'hA0, 68'h0, 68'h0, 1'b1);
    chk("ovf_ready1", rdy(), 68'h7);
    step(3'b001, 68'hA1, 68'h0, 68'h0, 1'b1);
    chk("ovf_ready2", rdy(), 68'h6);
    chk("ovf_before", 68'(bus.ovf), 68'h0);
    step(3'b001, 68'hA2, 68'h0, 68'h0, 1'b1);
    chk("ovf_set", 68'(bus.ovf), 68'h1);
    idle(5);
    chk("ovf_sticky", 68'(bus.ovf), 68'h1);
    drain();
    // rr is 1 now; then asynchronous reset with both channels valid
    b = cyc;
    expect_out(2'b11, 68'h61, 68'h60, b + 2);
    step(3'b011, 68'h60, 68'h61, 68'h0);
    step(3'b000, 68'h0, 68'h0, 68'h0);
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    chk("arst_alt", 68'(bus.ALT_INP), 68'h0);
    chk("arst_d0", bus.ALTDATA0, 68'h0);
    chk("arst_d1", bus.ALTDATA1, 68'h0);
    chk("arst_ovf", 68'(bus.ovf), 68'h0);
    chk("arst_ready", rdy(), 68'h7);
    @(posedge clk);
    #1;
    rst = 1;
    b = cyc;
    expect_out(2'b01, 68'h77, 68'h0, b + 2);
    step(3'b100, 68'h0, 68'h0, 68'h77);
    idle(3);
    drain();
    // src0/src1 full across a 3-cycle hold, then a burst checks rr landed on 2
    do_reset();
    b = cyc;
    expect_out(2'b11, 68'hB0, 68'hC0, b + 5);
    expect_out(2'b11, 68'hB1, 68'hC1, b + 6);
    expect_out(2'b11, 68'h42, 68'h40, b + 8);
    expect_out(2'b01, 68'h41, 68'h0, b + 9);
    step(3'b011, 68'hB0, 68'hC0, 68'h0, 1'b1);
    step(3'b011, 68'hB1, 68'hC1, 68'h0, 1'b1);
    chk("hold_ready", rdy(), 68'h4);
    step(3'b000, 68'h0, 68'h0, 68'h0, 1'b1);
    step(3'b000, 68'h0, 68'h0, 68'h0, 1'b1);
    idle(2);
    step(3'b111, 68'h40, 68'h41, 68'h42);
    idle(4);
    drain();
    // flush with one entry per FIFO and a concurrent src2 push
    do_reset();
    b = cyc;
    expect_out(2'b01, 68'hF2, 68'h0, b + 4);
    step(3'b111, 68'hD0, 68'hD1, 68'hD2, 1'b1);
    step(3'b100, 68'h0, 68'h0, 68'hEE, 1'b1, 1'b1);
    chk("flush_ready", rdy(), 68'h7);
    step(3'b100, 68'h0, 68'h0, 68'hF2);
    idle(4);
    chk("flush_ovf", 68'(bus.ovf), 68'h0);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_altinp_arb.md
# fpu_altinp_arb

Arbiter and buffer feeding the alternate-input port (ALT_INP / ALTDATA0 / ALTDATA1) of the third FPU lane pair in the H-half FP cluster. Three producers (integer-to-FP move, load-align, constant/convert unit) each push 68-bit operands into a private FIFO. The arbiter drains up to two entries per cycle in round-robin order onto the two ALTDATA channels, honouring a lane hold and a pipeline flush. All outputs are registered.

## Interface
- WIDTH, 68, operand width (H-half SIMD width).
- DEPTH, 2, entries per source FIFO (power of 2, ≥2).
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- src0_valid / src1_valid / src2_valid  in  1 each  push request from source n.
- src0_data / src1_data / src2_data  in  WIDTH each  operand from source n.
- src0_ready / src1_ready / src2_ready  out  1 each  FIFO n not full; combinational from occupancy only.
- hold  in  1  FPU lane cannot accept alt operands this cycle.
- flush  in  1  synchronous pipeline flush.
- ALT_INP  out  2  bit k = ALTDATAk valid this cycle.
- ALTDATA0, ALTDATA1  out  WIDTH each  alternate operands.
- ovf  out  1  sticky: push attempted while FIFO full.

## Operation
- Per source: DEPTH-entry FIFO with wrapping read/write pointers and a count of log2(DEPTH)+1 bits; srcN_ready = (count != DEPTH).
- Push: srcN_valid & srcN_ready writes at the write pointer on the clock edge. srcN_valid & ~srcN_ready drops the data and sets ovf (cleared only by reset).
- Eligibility: a source is eligible when its count before the edge is nonzero. An entry pushed at edge N is first eligible in cycle N+1; there is no same-cycle bypass.
- Round-robin pointer rr ∈ {0,1,2}, reset 0. Priority order is rr, rr+1, rr+2 (mod 3).
- Each cycle with hold=0 and flush=0:
  - first eligible source in priority order is granted to channel 0;
  - next eligible, distinct source is granted to channel 1;
  - a source gets at most one pop per cycle.
- rr update: (last granted source + 1) mod 3. With no grant, rr is unchanged.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance. A full FIFO does not accept a push in the cycle it is popped, because ready is computed from pre-edge count.
- Output registers:
  - ALT_INP[k] <= channel k granted;
  - ALTDATAk <= popped entry, or 0 when channel k is not granted.
  - Channel 1 is never valid unless channel 0 is valid.
- hold=1: no pops, rr held, ALT_INP <= 00, ALTDATA <= 0. Pushes continue normally.
- flush=1: all FIFO counts and pointers cleared, pushes in that cycle discarded, ALT_INP <= 00, ALTDATA <= 0. rr and ovf are kept. flush overrides hold.
- Reset values: ALT_INP=00, ALTDATA0=ALTDATA1=0, ovf=0, all counts 0 (so srcN_ready=1), rr=0.

## Timing
- Latency from push edge N to ALT_INP valid: visible after edge N+1 (one full cycle), given hold=0 at edge N+1.
- Throughput: 2 operands per cycle aggregate; 1 per cycle per source.
- ready deasserts in the cycle after the edge that fills the FIFO.
- Reset assertion mid-stream: all state clears immediately (asynchronous). The first push accepted after reset release appears at the earliest after the second edge.
- Single-cycle hold pulse: exactly one output bubble; no entries lost or reordered.

## Test plan
- Reset, then src1 pushes A=0x1 at edge 1 → ALT_INP=01, ALTDATA0=0x1 after edge 2; ALTDATA1=0; rr=2.
- All three sources hold 2 entries each (S0a,S0b,S1a,S1b,S2a,S2b), rr=0, no new pushes → cycle 1: ch0=S0a, ch1=S1a; cycle 2: ch0=S2a, ch1=S0b; cycle 3: ch0=S1b, ch1=S2b; cycle 4: ALT_INP=00.
- src0 pushes 3 consecutive cycles with hold=1 → third push sees src0_ready=0, ovf=1 persists; after hold drops, exactly 2 entries appear in order.
- Both FIFOs 0 and 1 full, hold=1 for 3 cycles → ALT_INP=00 throughout; on release, outputs match the first pops and rr advances once per grant cycle.
- flush asserted while each FIFO holds 1 entry and src2 pushes in the same cycle → ALT_INP=00 next cycle and thereafter; all ready=1; the src2 data never appears.
- rst asserted asynchronously mid-cycle with ALT_INP=11 → ALT_INP=00 and ALTDATA=0 immediately; ovf=0; ready=1.
